// File: rtl/ashi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : ashi_reg_bank
// Purpose  : ASHI register bank with NUM_RW control and NUM_RO status registers.
//            Optional pending-interrupt register: define ASHI_REG_BANK_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ashi_reg_bank #(
    parameter int          NUM_RW     = 8,
    parameter int          NUM_RO     = 8,
    parameter int          RD_WAIT    = 2,
    parameter int          WR_WAIT    = 1,
    parameter logic [31:0] CTRL_RESET = 32'h0
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [31:0]                             ASHI_WINDX,
    input  logic [31:0]                             ASHI_WDATA,
    input  logic                                    ASHI_WRITE,
    output logic                                    ASHI_WIDLE,
    output logic [1:0]                              ASHI_WRESP,
    input  logic [31:0]                             ASHI_RINDX,
    input  logic                                    ASHI_READ,
    output logic                                    ASHI_RIDLE,
    output logic [31:0]                             ASHI_RDATA,
    output logic [1:0]                              ASHI_RRESP,
    output logic [NUM_RW*32-1:0]                    ctrl_out,
    output logic [NUM_RW-1:0]                       wr_strobe,
    input  logic [(NUM_RO > 0 ? NUM_RO : 1)*32-1:0] status_in,
    input  logic [31:0]                             irq_src,
    output logic                                    irq
);

    localparam logic [1:0] c_okay    = 2'b00;
    localparam logic [1:0] c_slverr  = 2'b10;
    localparam logic [3:0] c_wr_wait = 4'(WR_WAIT);
    localparam logic [3:0] c_rd_wait = 4'(RD_WAIT);

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_WAIT = 1'b1} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_WAIT = 1'b1} rstate_t;

    wstate_t           r_wstate, w_wstate_nxt;
    rstate_t           r_rstate, w_rstate_nxt;
    logic [3:0]        r_wcnt, r_rcnt;
    logic [1:0]        r_wresp, r_rresp, w_rresp;
    logic [31:0]       r_rdata, w_rdata;
    logic [31:0]       r_ctrl [NUM_RW];
    logic [NUM_RW-1:0] r_wr_strobe;
    logic              w_wr_go, w_rd_go, w_widx_rw, w_widx_irq;

    // Requests arriving during a wait phase are dropped.
    assign w_wr_go   = ASHI_WRITE && (r_wstate == W_IDLE);
    assign w_rd_go   = ASHI_READ  && (r_rstate == R_IDLE);
    assign w_widx_rw = (ASHI_WINDX < 32'(NUM_RW));

    // ---------------- write FSM ----------------
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_wr_go && (c_wr_wait != 4'd0)) w_wstate_nxt = W_WAIT;
            W_WAIT:  if (r_wcnt == 4'd1) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_wstate <= W_IDLE;
        else       r_wstate <= w_wstate_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wcnt  <= 4'd0;
            r_wresp <= c_okay;
        end else if (w_wr_go) begin
            r_wcnt  <= c_wr_wait;
            r_wresp <= (w_widx_rw || w_widx_irq) ? c_okay : c_slverr;
        end else if (r_wstate == W_WAIT) begin
            r_wcnt  <= r_wcnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_RW; i++) r_ctrl[i] <= CTRL_RESET;
            r_wr_strobe <= '0;
        end else begin
            r_wr_strobe <= '0;
            if (w_wr_go) begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (ASHI_WINDX == 32'(i)) begin
                        r_ctrl[i]      <= ASHI_WDATA;
                        r_wr_strobe[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- optional pending-interrupt register ----------------
`ifdef ASHI_REG_BANK_IRQ_EN
    localparam logic [31:0] c_irq_idx = 32'(NUM_RW + NUM_RO);

    logic [31:0] r_irq_src_q, r_pend, w_clr;
    logic        r_irq;

    assign w_widx_irq = (ASHI_WINDX == c_irq_idx);
    assign w_clr      = (w_wr_go && w_widx_irq) ? ASHI_WDATA : 32'h0;

    // A new source edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_src_q <= 32'h0;
            r_pend      <= 32'h0;
            r_irq       <= 1'b0;
        end else begin
            r_irq_src_q <= irq_src;
            r_pend      <= (r_pend & ~w_clr) | (irq_src & ~r_irq_src_q);
            r_irq       <= |r_pend;
        end
    end

    assign irq = r_irq;
`else
    logic w_unused_irq_src;

    assign w_widx_irq       = 1'b0;
    assign w_unused_irq_src = ^irq_src;
    assign irq              = 1'b0;
`endif

    // ---------------- read FSM ----------------
    always_comb begin
        w_rdata = 32'h0;
        w_rresp = c_slverr;
        for (int i = 0; i < NUM_RW; i++) begin
            if (ASHI_RINDX == 32'(i)) begin
                w_rdata = r_ctrl[i];
                w_rresp = c_okay;
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (ASHI_RINDX == 32'(NUM_RW + j)) begin
                w_rdata = status_in[32*j +: 32];
                w_rresp = c_okay;
            end
        end
`ifdef ASHI_REG_BANK_IRQ_EN
        if (ASHI_RINDX == c_irq_idx) begin
            w_rdata = r_pend;
            w_rresp = c_okay;
        end
`endif
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_rd_go && (c_rd_wait != 4'd0)) w_rstate_nxt = R_WAIT;
            R_WAIT:  if (r_rcnt == 4'd1) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rstate <= R_IDLE;
        else       r_rstate <= w_rstate_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rcnt  <= 4'd0;
            r_rdata <= 32'h0;
            r_rresp <= c_okay;
        end else if (w_rd_go) begin
            r_rcnt  <= c_rd_wait;
            r_rdata <= w_rdata;
            r_rresp <= w_rresp;
        end else if (r_rstate == R_WAIT) begin
            r_rcnt  <= r_rcnt - 4'd1;
        end
    end

    // ---------------- outputs ----------------
    generate
        for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl_out
            assign ctrl_out[32*g +: 32] = r_ctrl[g];
        end
    endgenerate

    assign wr_strobe  = r_wr_strobe;
    assign ASHI_WIDLE = (r_wstate == W_IDLE);
    assign ASHI_WRESP = r_wresp;
    assign ASHI_RIDLE = (r_rstate == R_IDLE);
    assign ASHI_RDATA = r_rdata;
    assign ASHI_RRESP = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_ashi_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_ashi_reg_bank
// Purpose  : Directed self-checking bench for ashi_reg_bank (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ashi_reg_bank;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  ASHI_WINDX, ASHI_WDATA, ASHI_RINDX, ASHI_RDATA;
    logic         ASHI_WRITE, ASHI_WIDLE, ASHI_READ, ASHI_RIDLE;
    logic [1:0]   ASHI_WRESP, ASHI_RRESP;
    logic [255:0] ctrl_out, status_in, exp_ctrl;
    logic [7:0]   wr_strobe, s1, s2;
    logic [31:0]  irq_src;
    logic         irq;
    int           tests = 0;
    int           fails = 0;
    int           low;

    always #5 clk = ~clk;

    ashi_reg_bank dut (
        .clk        (clk),
        .reset      (reset),
        .ASHI_WINDX (ASHI_WINDX),
        .ASHI_WDATA (ASHI_WDATA),
        .ASHI_WRITE (ASHI_WRITE),
        .ASHI_WIDLE (ASHI_WIDLE),
        .ASHI_WRESP (ASHI_WRESP),
        .ASHI_RINDX (ASHI_RINDX),
        .ASHI_READ  (ASHI_READ),
        .ASHI_RIDLE (ASHI_RIDLE),
        .ASHI_RDATA (ASHI_RDATA),
        .ASHI_RRESP (ASHI_RRESP),
        .ctrl_out   (ctrl_out),
        .wr_strobe  (wr_strobe),
        .status_in  (status_in),
        .irq_src    (irq_src),
        .irq        (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one write; report cycles WIDLE stayed low and the strobe on the two following cycles.
    task automatic wr(input logic [31:0] idx, input logic [31:0] data,
                      output int n, output logic [7:0] st1, output logic [7:0] st2);
        ASHI_WINDX = idx;
        ASHI_WDATA = data;
        ASHI_WRITE = 1'b1;
        tick();
        ASHI_WRITE = 1'b0;
        st1 = wr_strobe;
        st2 = 8'hxx;
        n   = 0;
        while (ASHI_WIDLE !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (n == 1) st2 = wr_strobe;
        end
    endtask

    task automatic rd(input logic [31:0] idx, output int n);
        ASHI_RINDX = idx;
        ASHI_READ  = 1'b1;
        tick();
        ASHI_READ  = 1'b0;
        n = (ASHI_RIDLE === 1'b1) ? 0 : 1;
        while (ASHI_RIDLE !== 1'b1 && n < 40) begin
            tick();
            if (ASHI_RIDLE !== 1'b1) n++;
        end
    endtask

    initial begin
        reset = 1'b1;
        ASHI_WINDX = '0; ASHI_WDATA = '0; ASHI_WRITE = 1'b0;
        ASHI_RINDX = '0; ASHI_READ  = 1'b0;
        irq_src = '0;
        for (int i = 0; i < 8; i++) status_in[32*i +: 32] = 32'hC000_0000 | 32'(i);
        status_in[95:64] = 32'h1234_5678;
        exp_ctrl = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_widle", ASHI_WIDLE, 1);
        check("rst_ridle", ASHI_RIDLE, 1);
        check("rst_wresp", ASHI_WRESP, 0);
        check("rst_rresp", ASHI_RRESP, 0);
        check("rst_rdata", ASHI_RDATA, 0);
        check("rst_strobe", wr_strobe, 0);
        check("rst_ctrl", ctrl_out === 256'h0, 1);
        check("rst_irq", irq, 0);

        // Control write, index 3
        wr(32'd3, 32'hA5A5_0001, low, s1, s2);
        exp_ctrl[127:96] = 32'hA5A5_0001;
        check("w3_low_cycles", low, 1);
        check("w3_strobe", s1, 8'h08);
        check("w3_strobe_clear", s2, 8'h00);
        check("w3_wresp", ASHI_WRESP, 2'b00);
        check("w3_ctrl", ctrl_out[127:96], 32'hA5A5_0001);

        // Status read, index 10
        rd(32'd10, low);
        check("r10_low_cycles", low, 2);
        check("r10_rdata", ASHI_RDATA, 32'h1234_5678);
        check("r10_rresp", ASHI_RRESP, 2'b00);

        // Write to read-only index, then out-of-range read
        wr(32'd9, 32'hFFFF_FFFF, low, s1, s2);
        check("w9_wresp", ASHI_WRESP, 2'b10);
        check("w9_strobe", s1, 8'h00);
        check("w9_ctrl_unchanged", ctrl_out === exp_ctrl, 1);
        rd(32'd40, low);
        check("r40_rdata", ASHI_RDATA, 0);
        check("r40_rresp", ASHI_RRESP, 2'b10);
        rd(32'd3, low);
        check("r3_rdata", ASHI_RDATA, 32'hA5A5_0001);
        check("r3_rresp", ASHI_RRESP, 2'b00);
        rd(32'h8000_0003, low);
        check("rhi_rresp", ASHI_RRESP, 2'b10);
        check("rhi_rdata", ASHI_RDATA, 0);
        wr(32'h0001_0000, 32'h1, low, s1, s2);
        check("whi_wresp", ASHI_WRESP, 2'b10);
        check("whi_ctrl_unchanged", ctrl_out === exp_ctrl, 1);

        // Same-cycle read and write of index 0
        ASHI_WINDX = 32'd0; ASHI_WDATA = 32'h55; ASHI_WRITE = 1'b1;
        ASHI_RINDX = 32'd0; ASHI_READ  = 1'b1;
        tick();
        ASHI_WRITE = 1'b0; ASHI_READ = 1'b0;
        check("rw0_rdata_old", ASHI_RDATA, 0);
        check("rw0_rresp", ASHI_RRESP, 2'b00);
        check("rw0_ctrl_new", ctrl_out[31:0], 32'h55);
        check("rw0_strobe", wr_strobe, 8'h01);
        repeat (3) tick();

        // Reset in the middle of a read wait
        ASHI_RINDX = 32'd3; ASHI_READ = 1'b1;
        tick();
        ASHI_READ = 1'b0;
        check("mid_ridle_low", ASHI_RIDLE, 0);
        check("mid_rdata", ASHI_RDATA, 32'hA5A5_0001);
        reset = 1'b1;
        #1;
        check("arst_ridle", ASHI_RIDLE, 1);
        check("arst_rdata", ASHI_RDATA, 0);
        check("arst_ctrl", ctrl_out === 256'h0, 1);
        check("arst_widle", ASHI_WIDLE, 1);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_ridle", ASHI_RIDLE, 1);
        rd(32'd10, low);
        check("post_rst_low_cycles", low, 2);
        check("post_rst_rdata", ASHI_RDATA, 32'h1234_5678);

`ifdef ASHI_REG_BANK_IRQ_EN
        irq_src = 32'h10;
        tick();
        check("irq_lag", irq, 0);
        tick();
        check("irq_set", irq, 1);
        irq_src = 32'h0;
        tick();
        irq_src = 32'h10;
        wr(32'd16, 32'h10, low, s1, s2);
        check("irq_clr_wresp", ASHI_WRESP, 2'b00);
        check("irq_set_wins", irq, 1);
        rd(32'd16, low);
        check("pend_read", ASHI_RDATA, 32'h10);
        wr(32'd16, 32'h10, low, s1, s2);
        check("irq_cleared", irq, 0);
        rd(32'd16, low);
        check("pend_read_zero", ASHI_RDATA, 32'h0);
`else
        wr(32'd16, 32'h10, low, s1, s2);
        check("p_idx_wresp", ASHI_WRESP, 2'b10);
        rd(32'd16, low);
        check("p_idx_rresp", ASHI_RRESP, 2'b10);
        irq_src = 32'hFFFF_FFFF;
        repeat (2) tick();
        check("irq_tied_low", irq, 0);
        irq_src = 32'h0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
